mips_pipe_perf_counters: RTL and testbench

//   Parametrised per-stage pipeline performance counter bank for the MIPS pipeline.
//   One counter per pipeline stage (IF/ID/EX/MEM/WB by default) counts valid, stall,

---
 rtl/mips_pipe_perf_counters.sv | 122 ++++++++++++
 tb/tb_mips_pipe_perf_counters.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipe_perf_counters.sv
// Per-stage pipeline performance counter bank with a snapshot shadow bank and
// registered readback, plus a free-running count of enabled cycles.
module mips_pipe_perf_counters #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_WIDTH  = 32,
    parameter bit SAT_MODE   = 1'b1,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pcen,
    input  logic [NUM_STAGES-1:0] stage_valid,
    input  logic [NUM_STAGES-1:0] stage_stall,
    input  logic [NUM_STAGES-1:0] stage_flush,
    input  logic [1:0]            mode,
    input  logic                  clear,
    input  logic                  snap,
    input  logic [SEL_WIDTH-1:0]  rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    output logic [NUM_STAGES-1:0] ovf,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_STALL = 2'b01,
        MODE_FLUSH = 2'b10,
        MODE_ALL   = 2'b11
    } countMode_e;

    countMode_e curMode;

    logic [CNT_WIDTH-1:0]  cnt_q    [NUM_STAGES];
    logic [CNT_WIDTH-1:0]  cnt_d    [NUM_STAGES];
    logic [CNT_WIDTH-1:0]  shadow_q [NUM_STAGES];
    logic [CNT_WIDTH-1:0]  shadow_d [NUM_STAGES];
    logic [NUM_STAGES-1:0] ovf_q, ovf_d;
    logic [NUM_STAGES-1:0] incHit;
    logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]  rdData_q, rdData_d;
    logic                  rdValid_q, rdValid_d;
    logic [1:0]            mode_q;
    logic                  clearEvt;

    assign curMode  = countMode_e'(mode);
    // A mode change behaves exactly like a clear so counts never mix two event kinds.
    assign clearEvt = clear | (mode != mode_q);

    always_comb begin
        incHit = '0;
        case (curMode)
            MODE_RUN:   incHit = {NUM_STAGES{pcen}} & stage_valid & ~stage_stall;
            MODE_STALL: incHit = {NUM_STAGES{pcen}} & stage_stall;
            MODE_FLUSH: incHit = {NUM_STAGES{pcen}} & stage_flush;
            MODE_ALL:   incHit = {NUM_STAGES{pcen}};
            default:    incHit = '0;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_STAGES; i++) begin
            cnt_d[i]    = cnt_q[i];
            shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
            if (clearEvt) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (incHit[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = SAT_MODE ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        rdData_d  = '0;
        rdValid_d = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (rd_sel == SEL_WIDTH'(i)) begin
                rdData_d  = shadow_q[i];
                rdValid_d = 1'b1;
            end
        end
    end

    assign cycle_d = pcen ? cycle_q + CNT_WIDTH'(1) : cycle_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            ovf_q     <= '0;
            cycle_q   <= '0;
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
            mode_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                cnt_q[i]    <= cnt_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            ovf_q     <= ovf_d;
            cycle_q   <= cycle_d;
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
            mode_q    <= mode;
        end
    end

    assign rd_data     = rdData_q;
    assign rd_valid    = rdValid_q;
    assign ovf         = ovf_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_mips_pipe_perf_counters.sv
// Bench for the counter bank: one 32-bit saturating instance and two 4-bit
// instances (saturating and wrapping) share stimulus and a behavioural model.
module tb_mips_pipe_perf_counters;

    logic       clk = 1'b0;
    logic       reset, pcen, clear, snap;
    logic [4:0] stageValid, stageStall, stageFlush;
    logic [1:0] mode;
    logic [2:0] rdSel;

    logic [31:0] rdDataA, cycA;
    logic [3:0]  rdDataS, cycS, rdDataW, cycW;
    logic        rdValidA, rdValidS, rdValidW;
    logic [4:0]  ovfA, ovfS, ovfW;

    logic [31:0] obsData [3];
    logic [31:0] obsCyc  [3];
    logic        obsValid[3];
    logic [4:0]  obsOvf  [3];

    longint unsigned liveM   [3][5];
    longint unsigned shadowM [3][5];
    longint unsigned cycM    [3];
    longint unsigned rdDataM [3];
    bit              rdValidM[3];
    bit [4:0]        ovfM    [3];
    bit [1:0]        modeM   [3];

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    mips_pipe_perf_counters #(.NUM_STAGES(5), .CNT_WIDTH(32), .SAT_MODE(1'b1), .SEL_WIDTH(3)) dutA (
        .clk(clk), .reset(reset), .pcen(pcen), .stage_valid(stageValid), .stage_stall(stageStall),
        .stage_flush(stageFlush), .mode(mode), .clear(clear), .snap(snap), .rd_sel(rdSel),
        .rd_data(rdDataA), .rd_valid(rdValidA), .ovf(ovfA), .cycle_count(cycA));

    mips_pipe_perf_counters #(.NUM_STAGES(5), .CNT_WIDTH(4), .SAT_MODE(1'b1), .SEL_WIDTH(3)) dutS (
        .clk(clk), .reset(reset), .pcen(pcen), .stage_valid(stageValid), .stage_stall(stageStall),
        .stage_flush(stageFlush), .mode(mode), .clear(clear), .snap(snap), .rd_sel(rdSel),
        .rd_data(rdDataS), .rd_valid(rdValidS), .ovf(ovfS), .cycle_count(cycS));

    mips_pipe_perf_counters #(.NUM_STAGES(5), .CNT_WIDTH(4), .SAT_MODE(1'b0), .SEL_WIDTH(3)) dutW (
        .clk(clk), .reset(reset), .pcen(pcen), .stage_valid(stageValid), .stage_stall(stageStall),
        .stage_flush(stageFlush), .mode(mode), .clear(clear), .snap(snap), .rd_sel(rdSel),
        .rd_data(rdDataW), .rd_valid(rdValidW), .ovf(ovfW), .cycle_count(cycW));

    assign obsData[0]  = rdDataA;
    assign obsData[1]  = {28'd0, rdDataS};
    assign obsData[2]  = {28'd0, rdDataW};
    assign obsCyc[0]   = cycA;
    assign obsCyc[1]   = {28'd0, cycS};
    assign obsCyc[2]   = {28'd0, cycW};
    assign obsValid[0] = rdValidA;
    assign obsValid[1] = rdValidS;
    assign obsValid[2] = rdValidW;
    assign obsOvf[0]   = ovfA;
    assign obsOvf[1]   = ovfS;
    assign obsOvf[2]   = ovfW;

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                liveM[k][i]   = 0;
                shadowM[k][i] = 0;
            end
            cycM[k]     = 0;
            rdDataM[k]  = 0;
            rdValidM[k] = 1'b0;
            ovfM[k]     = '0;
            modeM[k]    = '0;
        end
    endtask

    // Instance 0 is 32-bit saturating, 1 is 4-bit saturating, 2 is 4-bit wrapping.
    task automatic modelStep();
        longint unsigned maxv;
        int sel;
        bit hit;
        if (reset) begin
            modelReset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                maxv = (k == 0) ? 64'hFFFF_FFFF : 64'hF;
                sel  = int'(rdSel);
                if (sel < 5) begin
                    rdDataM[k]  = shadowM[k][sel];
                    rdValidM[k] = 1'b1;
                end else begin
                    rdDataM[k]  = 0;
                    rdValidM[k] = 1'b0;
                end
                if (snap)
                    for (int i = 0; i < 5; i++) shadowM[k][i] = liveM[k][i];
                if (clear || (mode != modeM[k])) begin
                    for (int i = 0; i < 5; i++) liveM[k][i] = 0;
                    ovfM[k] = '0;
                end else if (pcen) begin
                    for (int i = 0; i < 5; i++) begin
                        case (mode)
                            2'b00:   hit = stageValid[i] && !stageStall[i];
                            2'b01:   hit = stageStall[i];
                            2'b10:   hit = stageFlush[i];
                            default: hit = 1'b1;
                        endcase
                        if (hit) begin
                            if (liveM[k][i] == maxv) begin
                                ovfM[k][i]  = 1'b1;
                                liveM[k][i] = (k == 2) ? 0 : maxv;
                            end else begin
                                liveM[k][i] = liveM[k][i] + 1;
                            end
                        end
                    end
                end
                if (pcen) cycM[k] = (cycM[k] + 1) & maxv;
                modeM[k] = mode;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        modelReset();
        tick();
        reset = 1'b0;
        pcen = 1'b0; clear = 1'b0; snap = 1'b0; mode = 2'b00; rdSel = 3'd0;
        stageValid = '0; stageStall = '0; stageFlush = '0;
    endtask

    task automatic test_reset();
        applyReset();
        mode = 2'b11;
        tick();
        pcen = 1'b1;
        repeat (7) tick();
        pcen = 1'b0; snap = 1'b1;
        tick();
        snap = 1'b0; rdSel = 3'd0;
        tick();
        checkCount++;
        if (cycA !== 32'd7) $display("[TB] FAIL pre-reset cycle_count: got %0d expected 7", cycA);
        else passCount++;
        checkCount++;
        if (rdDataA !== 32'd7 || rdValidA !== 1'b1)
            $display("[TB] FAIL pre-reset rd_data: got %0d/%0d expected 7/1", rdDataA, rdValidA);
        else passCount++;
        #2;
        reset = 1'b1;
        #1;
        checkCount++;
        if (cycA !== 32'd0 || cycS !== 4'd0)
            $display("[TB] FAIL async reset cycle_count: got %0d/%0d expected 0/0", cycA, cycS);
        else passCount++;
        checkCount++;
        if (rdDataA !== 32'd0 || rdValidA !== 1'b0 || ovfA !== 5'd0)
            $display("[TB] FAIL async reset outputs: got data %0d valid %0d ovf %b expected 0 0 00000", rdDataA, rdValidA, ovfA);
        else passCount++;
        modelReset();
        tick();
        reset = 1'b0;
        mode = 2'b00;
    endtask

    task automatic test_mode00();
        applyReset();
        pcen = 1'b1; stageValid = 5'b11111;
        for (int c = 0; c < 10; c++) begin
            stageStall = (c == 2 || c == 5 || c == 8) ? 5'b00100 : 5'b00000;
            tick();
        end
        pcen = 1'b0; stageStall = '0; snap = 1'b1;
        tick();
        snap = 1'b0; rdSel = 3'd2;
        tick();
        checkCount++;
        if (rdDataA !== 32'd7 || rdValidA !== 1'b1)
            $display("[TB] FAIL mode00 stage2: got %0d/%0d expected 7/1", rdDataA, rdValidA);
        else passCount++;
        rdSel = 3'd0;
        tick();
        checkCount++;
        if (rdDataA !== 32'd10) $display("[TB] FAIL mode00 stage0: got %0d expected 10", rdDataA);
        else passCount++;
        checkCount++;
        if (cycA !== 32'd10) $display("[TB] FAIL mode00 cycle_count: got %0d expected 10", cycA);
        else passCount++;
    endtask

    task automatic test_overflow();
        applyReset();
        mode = 2'b11;
        tick();
        pcen = 1'b1;
        repeat (20) tick();
        pcen = 1'b0; snap = 1'b1;
        tick();
        snap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rdSel = 3'(i);
            tick();
            checkCount++;
            if (rdDataS !== 4'd15 || rdDataW !== 4'd4 || rdDataA !== 32'd20)
                $display("[TB] FAIL overflow stage%0d: got sat %0d wrap %0d wide %0d expected 15 4 20", i, rdDataS, rdDataW, rdDataA);
            else passCount++;
        end
        checkCount++;
        if (ovfS !== 5'b11111 || ovfW !== 5'b11111 || ovfA !== 5'b00000)
            $display("[TB] FAIL overflow flags: got %b %b %b expected 11111 11111 00000", ovfS, ovfW, ovfA);
        else passCount++;
        checkCount++;
        if (cycS !== 4'd4 || cycW !== 4'd4 || cycA !== 32'd20)
            $display("[TB] FAIL overflow cycle_count: got %0d %0d %0d expected 4 4 20", cycS, cycW, cycA);
        else passCount++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkCount++;
        if (ovfS !== 5'd0 || ovfW !== 5'd0 || cycS !== 4'd4)
            $display("[TB] FAIL overflow clear: got ovf %b %b cycle %0d expected 00000 00000 4", ovfS, ovfW, cycS);
        else passCount++;
    endtask

    task automatic test_clear_snap();
        applyReset();
        pcen = 1'b1; stageValid = 5'b11111;
        repeat (9) tick();
        clear = 1'b1; snap = 1'b1;
        tick();
        clear = 1'b0; snap = 1'b0; pcen = 1'b0; rdSel = 3'd3;
        tick();
        checkCount++;
        if (rdDataA !== 32'd9) $display("[TB] FAIL clear+snap shadow: got %0d expected 9", rdDataA);
        else passCount++;
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        checkCount++;
        if (rdDataA !== 32'd0 || ovfA !== 5'd0)
            $display("[TB] FAIL clear+snap live: got %0d ovf %b expected 0 00000", rdDataA, ovfA);
        else passCount++;
    endtask

    task automatic test_mode_switch();
        applyReset();
        pcen = 1'b1; stageValid = 5'b11111;
        repeat (6) tick();
        pcen = 1'b0; snap = 1'b1;
        tick();
        snap = 1'b0; rdSel = 3'd2;
        tick();
        checkCount++;
        if (rdDataA !== 32'd6) $display("[TB] FAIL mode switch pre: got %0d expected 6", rdDataA);
        else passCount++;
        mode = 2'b01; stageStall = 5'b01010; pcen = 1'b1;
        tick();
        pcen = 1'b0; snap = 1'b1;
        tick();
        snap = 1'b0; rdSel = 3'd1;
        tick();
        checkCount++;
        if (rdDataA !== 32'd0 || ovfA !== 5'd0)
            $display("[TB] FAIL mode switch clear: got %0d ovf %b expected 0 00000", rdDataA, ovfA);
        else passCount++;
        pcen = 1'b1;
        repeat (3) tick();
        pcen = 1'b0; snap = 1'b1;
        tick();
        snap = 1'b0; rdSel = 3'd1;
        tick();
        checkCount++;
        if (rdDataA !== 32'd3) $display("[TB] FAIL mode switch stall count: got %0d expected 3", rdDataA);
        else passCount++;
        rdSel = 3'd0;
        tick();
        checkCount++;
        if (rdDataA !== 32'd0) $display("[TB] FAIL mode switch unstalled: got %0d expected 0", rdDataA);
        else passCount++;
        checkCount++;
        if (cycA !== 32'd10) $display("[TB] FAIL mode switch cycle_count: got %0d expected 10", cycA);
        else passCount++;
    endtask

    task automatic test_pcen_off();
        applyReset();
        pcen = 1'b1; stageValid = 5'b11111;
        repeat (4) tick();
        pcen = 1'b0;
        repeat (8) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0; rdSel = 3'd0;
        tick();
        checkCount++;
        if (rdDataA !== 32'd4 || rdValidA !== 1'b1)
            $display("[TB] FAIL pcen off hold: got %0d/%0d expected 4/1", rdDataA, rdValidA);
        else passCount++;
        rdSel = 3'd5;
        tick();
        checkCount++;
        if (rdDataA !== 32'd0 || rdValidA !== 1'b0)
            $display("[TB] FAIL out-of-range read: got %0d/%0d expected 0/0", rdDataA, rdValidA);
        else passCount++;
        checkCount++;
        if (cycA !== 32'd4) $display("[TB] FAIL pcen off cycle_count: got %0d expected 4", cycA);
        else passCount++;
    endtask

    // Random traffic on all controls, compared each cycle against the model.
    task automatic test_random();
        applyReset();
        for (int c = 0; c < 300; c++) begin
            pcen       = ($urandom_range(3) != 0);
            stageValid = 5'($urandom);
            stageStall = 5'($urandom);
            stageFlush = 5'($urandom);
            clear      = ($urandom_range(31) == 0);
            snap       = ($urandom_range(7) == 0);
            rdSel      = 3'($urandom_range(7));
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            tick();
            for (int k = 0; k < 3; k++) begin
                checkCount++;
                if (obsCyc[k] !== 32'(cycM[k]))
                    $display("[TB] FAIL random cycle_count inst%0d cyc%0d: got %0d expected %0d", k, c, obsCyc[k], cycM[k]);
                else passCount++;
                checkCount++;
                if (obsOvf[k] !== ovfM[k])
                    $display("[TB] FAIL random ovf inst%0d cyc%0d: got %b expected %b", k, c, obsOvf[k], ovfM[k]);
                else passCount++;
                checkCount++;
                if (obsData[k] !== 32'(rdDataM[k]) || obsValid[k] !== rdValidM[k])
                    $display("[TB] FAIL random readback inst%0d cyc%0d: got %0d/%0d expected %0d/%0d", k, c, obsData[k], obsValid[k], rdDataM[k], rdValidM[k]);
                else passCount++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; pcen = 1'b0; clear = 1'b0; snap = 1'b0; mode = 2'b00; rdSel = 3'd0;
        stageValid = '0; stageStall = '0; stageFlush = '0;
        modelReset();
        test_reset();
        test_mode00();
        test_overflow();
        test_clear_snap();
        test_mode_switch();
        test_pcen_off();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
